// File: rtl/mux_fifo_pkg.sv
// Shared types and helpers for the mux_fifo datapath: arbiter state, pipe modes, round-robin pick.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package mux_fifo_pkg;

    // Output pipe configurations.
    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_VLD    = 2'b01;
    localparam logic [1:0] MODE_RDY    = 2'b10;
    localparam logic [1:0] MODE_FULL   = 2'b11;

    // Largest supported requester count; the pick function works on vectors of this width.
    localparam int MAX_SRC = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Ascending search from ptr, wrapping at n; only indices below n are ever visited.
    function automatic pick_t rr_pick(input logic [MAX_SRC-1:0] vld,
                                      input logic [3:0]         ptr,
                                      input int                 n);
        pick_t r;
        int    idx;
        r = '0;
        for (int k = 0; k < MAX_SRC; k++) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!r.found && vld[idx[3:0]]) begin
                    r.found = 1'b1;
                    r.idx   = 4'(idx);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe.sv
// Generic valid/ready pipe stage: direct, valid-registered, ready-registered (skid) or fully registered.
// Latency: 0 (direct), 1 (vld/full), 0 or 1 (rdy, 1 only after a stall).
// Backpressure: dst_rdy low stalls; full mode absorbs one extra beat so src_rdy is a register.
module pipe
    import mux_fifo_pkg::*;
#(
    parameter logic [1:0] MODE       = MODE_FULL,
    parameter int         DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_rst,
    input  logic                  src_vld,
    output logic                  src_rdy,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  dst_vld,
    input  logic                  dst_rdy,
    output logic [DATA_WIDTH-1:0] dst_data
);

    // a_* is the output register, b_* the skid register.
    logic                  a_vld;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  b_vld;
    logic [DATA_WIDTH-1:0] b_data;

    // Output and ready selection for the configured mode.
    always_comb begin
        src_rdy  = 1'b0;
        dst_vld  = 1'b0;
        dst_data = '0;
        case (MODE)
            MODE_DIRECT: begin
                src_rdy  = dst_rdy;
                dst_vld  = src_vld;
                dst_data = src_data;
            end
            MODE_VLD: begin
                src_rdy  = !a_vld || dst_rdy;
                dst_vld  = a_vld;
                dst_data = a_data;
            end
            MODE_RDY: begin
                src_rdy  = !b_vld;
                dst_vld  = b_vld || src_vld;
                dst_data = b_vld ? b_data : (src_vld ? src_data : '0);
            end
            default: begin
                src_rdy  = !b_vld;
                dst_vld  = a_vld;
                dst_data = a_data;
            end
        endcase
    end

    // Register updates; the skid register only fills while the output side is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld  <= 1'b0;
            a_data <= '0;
            b_vld  <= 1'b0;
            b_data <= '0;
        end else if (soft_rst) begin
            a_vld  <= 1'b0;
            a_data <= '0;
            b_vld  <= 1'b0;
            b_data <= '0;
        end else begin
            case (MODE)
                MODE_VLD: begin
                    if (src_rdy) begin
                        a_vld <= src_vld;
                        if (src_vld) begin
                            a_data <= src_data;
                        end
                    end
                end
                MODE_RDY: begin
                    if (b_vld) begin
                        if (dst_rdy) begin
                            b_vld <= 1'b0;
                        end
                    end else if (src_vld && !dst_rdy) begin
                        b_vld  <= 1'b1;
                        b_data <= src_data;
                    end
                end
                MODE_FULL: begin
                    if (dst_rdy || !a_vld) begin
                        a_vld  <= b_vld || (src_vld && src_rdy);
                        a_data <= b_vld ? b_data : src_data;
                        b_vld  <= 1'b0;
                    end else if (src_vld && src_rdy) begin
                        b_vld  <= 1'b1;
                        b_data <= src_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/rr_grant.sv
// Round-robin grant: combinational pick from the pointer, pointer advances past each finished packet.
// Latency: grant is combinational; pointer updates on the clock after adv.
// Backpressure: none of its own; adv is only raised on a completed last-beat handshake.
module rr_grant
    import mux_fifo_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               soft_rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               adv,
    input  logic [ID_W-1:0]    adv_idx,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_found
);

    logic [ID_W-1:0] rr_ptr;
    pick_t           pick;

    // First requester at or after the pointer, in ascending order with wrap.
    always_comb begin
        pick      = rr_pick(MAX_SRC'(req), 4'(rr_ptr), NUM_SRC);
        gnt_found = pick.found;
        gnt_idx   = ID_W'(pick.idx);
    end

    // Pointer moves one past the requester that just finished; wraps explicitly at NUM_SRC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (soft_rst) begin
            rr_ptr <= '0;
        end else if (adv) begin
            rr_ptr <= (adv_idx == ID_W'(NUM_SRC - 1)) ? '0 : adv_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Packet-aware round-robin arbiter/mux: a requester keeps the grant until its last beat handshakes.
// Latency: set by OUT_MODE of the output pipe (0 or 1 cycle); no bubble between packets.
// Backpressure: dst_rdy flows back through the pipe to the single granted src_rdy bit.
module rr_arb_mux
    import mux_fifo_pkg::*;
#(
    parameter int         NUM_SRC    = 4,
    parameter int         DATA_WIDTH = 32,
    parameter logic [1:0] OUT_MODE   = MODE_FULL,
    localparam int        ID_W       = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          soft_rst,
    input  logic [NUM_SRC-1:0]            src_vld,
    output logic [NUM_SRC-1:0]            src_rdy,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_last,
    output logic                          dst_vld,
    input  logic                          dst_rdy,
    output logic [DATA_WIDTH-1:0]         dst_data,
    output logic                          dst_last,
    output logic [ID_W-1:0]               dst_id
);

    localparam int PW = DATA_WIDTH + 1 + ID_W;

    arb_state_t            state_q, state_d;
    logic [ID_W-1:0]       lock_q, lock_d;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt_found;
    logic [ID_W-1:0]       sel;
    logic                  active;
    logic                  adv;
    logic                  m_vld;
    logic                  m_rdy;
    logic                  m_last;
    logic                  m_hs;
    logic [DATA_WIDTH-1:0] m_data;
    logic [PW-1:0]         p_dst;
    logic [DATA_WIDTH-1:0] data_arr [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign data_arr[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign src_rdy[i]  = (active && sel == ID_W'(i)) ? m_rdy : 1'b0;
    end

    rr_grant #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_grant (
        .clk       (clk),
        .rst_n     (rst_n),
        .soft_rst  (soft_rst),
        .req       (src_vld),
        .adv       (adv),
        .adv_idx   (sel),
        .gnt_idx   (gnt_idx),
        .gnt_found (gnt_found)
    );

    // Select the granted requester; in LOCKED only the owner is visible even if it pauses.
    always_comb begin
        sel    = (state_q == LOCKED) ? lock_q : gnt_idx;
        active = !soft_rst && ((state_q == LOCKED) || gnt_found);
        m_vld  = active && src_vld[sel];
        m_last = src_last[sel];
        m_data = data_arr[sel];
        m_hs   = m_vld && m_rdy;
    end

    // Next state: any grant that does not complete its packet this cycle becomes a lock.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    if (m_hs && m_last) begin
                        adv = 1'b1;
                    end else begin
                        lock_d  = gnt_idx;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (m_hs && m_last) begin
                    adv     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else if (soft_rst) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    pipe #(
        .MODE       (OUT_MODE),
        .DATA_WIDTH (PW)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .soft_rst (soft_rst),
        .src_vld  (m_vld),
        .src_rdy  (m_rdy),
        .src_data ({sel, m_last, m_data}),
        .dst_vld  (dst_vld),
        .dst_rdy  (dst_rdy),
        .dst_data (p_dst)
    );

    assign {dst_id, dst_last, dst_data} = p_dst;

endmodule
